demux_1xn_stream: RTL and testbench

//  Registered, flow-controlled 1-to-CH demultiplexer. Next generation of the

---
 rtl/demux_1xn_stream.sv | 117 +++++++++++
 tb/tb_demux_1xn_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: registered, flow-controlled 1-to-CH stream demultiplexer.
// Each accepted input word is steered by select s into a one-entry output
// register per channel. Each channel has its own valid/ready handshake.
// Optional feature macro: DEMUX_BCAST_EN adds a bcast input. A broadcast
// writes the word to all channels at once, and only when every channel can
// take it.
module demux_1xn_stream #(
    parameter int n  = 3,
    parameter int CH = 8,
    parameter int W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    f,
    input  logic            en,
    input  logic [n-1:0]    s,
`ifdef DEMUX_BCAST_EN
    input  logic            bcast,
`endif
    output logic            rdy,
    output logic [CH*W-1:0] y,
    output logic [CH-1:0]   y_vld,
    input  logic [CH-1:0]   y_rdy,
    output logic            err
);

    // Select compare width: one extra bit so that CH == 2**n is representable.
    localparam int            NW      = n + 1;
    localparam logic [NW-1:0] CH_LIMIT = NW'(CH);

    logic [CH*W-1:0] y_q;
    logic [CH*W-1:0] y_d;
    logic [CH-1:0]   y_vld_q;
    logic [CH-1:0]   y_vld_d;
    logic            err_q;
    logic            err_d;

    logic [CH-1:0]   free_s;
    logic [CH-1:0]   sel_oh_s;
    logic [CH-1:0]   load_s;
    logic            sel_ok_s;
    logic            sel_free_s;
    logic            bcast_s;
    logic            drop_s;

    // Broadcast request qualifier; constant zero when the feature is not built.
`ifdef DEMUX_BCAST_EN
    assign bcast_s = en & bcast;
`else
    assign bcast_s = 1'b0;
`endif

    // Channel availability, select decode and input-ready computation.
    always_comb begin
        free_s     = ~y_vld_q | y_rdy;
        sel_ok_s   = ({1'b0, s} < CH_LIMIT);
        sel_oh_s   = '0;
        for (int i = 0; i < CH; i++) begin
            sel_oh_s[i] = ({1'b0, s} == NW'(i));
        end
        sel_free_s = |(sel_oh_s & free_s);
        if (bcast_s) begin
            rdy = &free_s;
        end else if (sel_ok_s) begin
            rdy = sel_free_s;
        end else begin
            // Out-of-range selects are always taken and then dropped, so the
            // producer can never deadlock on them.
            rdy = 1'b1;
        end
    end

    // Per-channel load strobes and dropped-word detection.
    always_comb begin
        load_s = '0;
        for (int i = 0; i < CH; i++) begin
            load_s[i] = en & rdy & (bcast_s | (sel_ok_s & sel_oh_s[i]));
        end
        drop_s = en & ~bcast_s & ~sel_ok_s;
    end

    // Next-state for the channel registers: a load wins over a drain.
    // Data is held (not cleared) on drain.
    always_comb begin
        y_d     = y_q;
        y_vld_d = y_vld_q;
        err_d   = drop_s;
        for (int i = 0; i < CH; i++) begin
            if (load_s[i]) begin
                y_d[i*W +: W] = f;
                y_vld_d[i]    = 1'b1;
            end else if (y_rdy[i]) begin
                y_vld_d[i]    = 1'b0;
            end else begin
                y_vld_d[i]    = y_vld_q[i];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_vld_q <= '0;
            err_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            err_q   <= err_d;
        end
    end

    assign y     = y_q;
    assign y_vld = y_vld_q;
    assign err   = err_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream (n=3, CH=6, W=8).
// The scoreboard keeps one queue of expected words per channel, plus the
// last word written to each channel. A monitor on the falling edge compares
// every output against that model.
module tb_demux_1xn_stream;

    localparam int N  = 3;
    localparam int CH = 6;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    f;
    logic            en;
    logic [N-1:0]    s;
    logic            rdy;
    logic [CH*W-1:0] y;
    logic [CH-1:0]   y_vld;
    logic [CH-1:0]   y_rdy;
    logic            err;
`ifdef DEMUX_BCAST_EN
    logic            bcast;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [CH][$];
    logic [W-1:0] last_w [CH];
    logic         exp_err = 1'b0;
    logic         started = 1'b0;

    always #5 clk = ~clk;

    demux_1xn_stream #(.n(N), .CH(CH), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .f     (f),
        .en    (en),
        .s     (s),
`ifdef DEMUX_BCAST_EN
        .bcast (bcast),
`endif
        .rdy   (rdy),
        .y     (y),
        .y_vld (y_vld),
        .y_rdy (y_rdy),
        .err   (err)
    );

    function automatic logic bc_req();
`ifdef DEMUX_BCAST_EN
        return en & bcast;
`else
        return 1'b0;
`endif
    endfunction

    // Reference ready: a channel can take a word if it holds nothing or is
    // being emptied this cycle. A broadcast needs every channel to be able to.
    function automatic logic model_rdy();
        if (bc_req()) begin
            for (int i = 0; i < CH; i++)
                if (q[i].size() != 0 && !y_rdy[i]) return 1'b0;
            return 1'b1;
        end
        if (int'(s) >= CH) return 1'b1;
        return (q[s].size() == 0) || y_rdy[s];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard update on each rising edge, using the inputs just sampled.
    always @(posedge clk) begin
        logic acc;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                q[i].delete();
                last_w[i] = '0;
            end
            exp_err = 1'b0;
        end else begin
            acc = en && model_rdy();
            for (int i = 0; i < CH; i++)
                if (q[i].size() != 0 && y_rdy[i]) void'(q[i].pop_front());
            if (acc && bc_req()) begin
                for (int i = 0; i < CH; i++) begin
                    q[i].push_back(f);
                    last_w[i] = f;
                end
            end else if (acc && int'(s) < CH) begin
                q[s].push_back(f);
                last_w[s] = f;
            end
            exp_err = en && !bc_req() && int'(s) >= CH;
        end
        started = 1'b1;
    end

    // Monitor: compare outputs against the model away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            chk("rdy", 32'(rdy), 32'(model_rdy()));
            chk("err", 32'(err), 32'(exp_err));
            for (int i = 0; i < CH; i++) begin
                chk($sformatf("y_vld[%0d]", i), 32'(y_vld[i]), 32'(q[i].size() != 0));
                if (q[i].size() != 0)
                    chk($sformatf("y[%0d]", i), 32'(y[i*W +: W]), 32'(q[i][0]));
                else
                    chk($sformatf("y_stale[%0d]", i), 32'(y[i*W +: W]), 32'(last_w[i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [W-1:0] d);
        en = 1'b1;
        s  = N'(sel);
        f  = d;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        s     = '0;
        f     = 8'h00;
        y_rdy = '1;
`ifdef DEMUX_BCAST_EN
        bcast = 1'b0;
`endif
        // Reset held with en asserted.
        cyc();
        cyc();
        rst_n = 1'b1;
        en    = 1'b0;
        cyc();

        // Sweep every implemented channel back to back.
        for (int i = 0; i < CH; i++) send(i, 8'hA0 + 8'(i));
        en = 1'b0;
        cyc();

        // Backpressure on channel 2 while channel 3 keeps flowing.
        y_rdy[2] = 1'b0;
        send(2, 8'h11);
        send(3, 8'h33);
        send(2, 8'h22);
        send(2, 8'h22);
        y_rdy[2] = 1'b1;
        send(2, 8'h22);
        send(3, 8'h34);
        en = 1'b0;
        cyc();

        // Invalid selects back to back.
        send(6, 8'hFF);
        send(7, 8'hFF);
        en = 1'b0;
        cyc();
        cyc();

        // Reset with channels 1 and 4 full and stalled.
        y_rdy[1] = 1'b0;
        y_rdy[4] = 1'b0;
        send(1, 8'h41);
        send(4, 8'h44);
        en    = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        y_rdy = '1;
        send(1, 8'h51);
        en = 1'b0;
        cyc();

`ifdef DEMUX_BCAST_EN
        // Broadcast blocked by one full, stalled channel, then released.
        y_rdy[5] = 1'b0;
        send(5, 8'h55);
        bcast = 1'b1;
        send(0, 8'h5A);
        send(0, 8'h5A);
        y_rdy[5] = 1'b1;
        send(0, 8'h5A);
        bcast = 1'b0;
        en    = 1'b0;
        cyc();
`endif

        // Randomized traffic with random consumer backpressure and rare resets.
        for (int k = 0; k < 3000; k++) begin
            en    = ($urandom_range(0, 3) != 0);
            s     = N'($urandom_range(0, 7));
            f     = W'($urandom);
            y_rdy = CH'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef DEMUX_BCAST_EN
            bcast = ($urandom_range(0, 9) == 0);
`endif
            cyc();
        end

        // Drain.
        rst_n = 1'b1;
        en    = 1'b0;
        y_rdy = '1;
`ifdef DEMUX_BCAST_EN
        bcast = 1'b0;
`endif
        cyc();
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
